frame_extrema_tracker: RTL and testbench

- Streaming stage that consumes unsigned WIDTH-bit samples, one per valid/ready handshake.
- Sample pairs go through the 4-bit magnitude-compare function to characterise each frame of FRAME_LEN samples.
- Per frame it reports maximum, minimum, and the number of rising, falling and flat steps between consecutive samples.
- It sits directly downstream of the comparator stage's operand source and turns raw gt/lt/eq decisions into per-frame statistics for the next stage.

---
 rtl/frame_extrema_pkg.sv | 12 +
 rtl/frame_extrema_tracker_mag_compare.sv | 14 +
 rtl/frame_extrema_tracker.sv | 98 +++++++++
 tb/tb_frame_extrema_tracker.sv | 137 +++++++++++++
 4 files changed

// File: rtl/frame_extrema_pkg.sv
// frame_extrema_pkg: shared state encodings, default sizes and clog2 for the frame extrema tracker
package frame_extrema_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_FRAME_LEN = 8;
    typedef enum logic [1:0] {FIRST = 2'd0, ACCUM = 2'd1, RESULT = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/frame_extrema_tracker_mag_compare.sv
// mag_compare: unsigned magnitude comparator with one-hot gt/lt/eq
module mag_compare #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    assign gt = a > b;
    assign lt = a < b;
    assign eq = a == b;
endmodule

// File: rtl/frame_extrema_tracker.sv
// frame_extrema_tracker: per-frame max/min and rise/fall/flat step counts over a valid/ready sample stream
module frame_extrema_tracker
    import frame_extrema_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CW = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CW-1:0]    out_rise,
    output logic [CW-1:0]    out_fall,
    output logic [CW-1:0]    out_flat
);
    state_t state_q, state_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d, prev_q, prev_d;
    logic [CW-1:0] rise_q, rise_d, fall_q, fall_d, flat_q, flat_d;
    logic [7:0] idx_q, idx_d;
    logic valid_q, valid_d;
    logic step_gt, step_lt, step_eq, max_gt, max_lt, max_eq, min_gt, min_lt, min_eq;
    logic unused_cmp;
    mag_compare #(.WIDTH(WIDTH)) u_step (.a(in_data), .b(prev_q), .gt(step_gt), .lt(step_lt), .eq(step_eq));
    mag_compare #(.WIDTH(WIDTH)) u_max  (.a(in_data), .b(max_q),  .gt(max_gt),  .lt(max_lt),  .eq(max_eq));
    mag_compare #(.WIDTH(WIDTH)) u_min  (.a(in_data), .b(min_q),  .gt(min_gt),  .lt(min_lt),  .eq(min_eq));
    assign unused_cmp = ^{max_lt, max_eq, min_gt, min_eq};
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        prev_d  = prev_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        flat_d  = flat_q;
        idx_d   = idx_q;
        case (state_q)
            FIRST: if (in_valid) begin
                max_d   = in_data;
                min_d   = in_data;
                prev_d  = in_data;
                rise_d  = '0;
                fall_d  = '0;
                flat_d  = '0;
                idx_d   = 8'd1;
                state_d = (FRAME_LEN == 1) ? RESULT : ACCUM;
            end
            ACCUM: if (in_valid) begin
                rise_d  = rise_q + CW'(step_gt);
                fall_d  = fall_q + CW'(step_lt);
                flat_d  = flat_q + CW'(step_eq);
                max_d   = max_gt ? in_data : max_q;
                min_d   = min_lt ? in_data : min_q;
                prev_d  = in_data;
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'(FRAME_LEN - 1)) ? RESULT : ACCUM;
            end
            RESULT: state_d = out_ready ? FIRST : RESULT;
            default: state_d = FIRST;
        endcase
        valid_d = state_d == RESULT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FIRST;
            max_q   <= '0;
            min_q   <= '0;
            prev_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            flat_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flat_q  <= flat_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end
    assign in_ready  = state_q != RESULT;
    assign out_valid = valid_q;
    assign out_max   = max_q;
    assign out_min   = min_q;
    assign out_rise  = rise_q;
    assign out_fall  = fall_q;
    assign out_flat  = flat_q;
endmodule

// File: tb/tb_frame_extrema_tracker.sv
// tb_frame_extrema_tracker: directed checks of the frame extrema tracker at FRAME_LEN=4 and FRAME_LEN=1
module tb_frame_extrema_tracker;
    logic clk, rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_data, out_max, out_min;
    logic [1:0] out_rise, out_fall, out_flat;
    logic in_valid1, in_ready1, out_valid1, out_ready1;
    logic [3:0] in_data1, out_max1, out_min1;
    logic [0:0] out_rise1, out_fall1, out_flat1;
    int vectors, miscompares, idle;
    frame_extrema_tracker #(.WIDTH(4), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
        .out_rise(out_rise), .out_fall(out_fall), .out_flat(out_flat)
    );
    frame_extrema_tracker #(.WIDTH(4), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_max(out_max1), .out_min(out_min1),
        .out_rise(out_rise1), .out_fall(out_fall1), .out_flat(out_flat1)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic put(input logic [3:0] v, output int n);
        in_data = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("put_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask
    task automatic res(input string tag, input int mx, input int mn, input int r, input int f, input int fl);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_max"}, 32'(out_max), 32'(mx));
        chk({tag, "_min"}, 32'(out_min), 32'(mn));
        chk({tag, "_rise"}, 32'(out_rise), 32'(r));
        chk({tag, "_fall"}, 32'(out_fall), 32'(f));
        chk({tag, "_flat"}, 32'(out_flat), 32'(fl));
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fields", 32'({out_max, out_min, out_rise, out_fall, out_flat}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        // basic frame 1,4,4,2
        put(4'd1, idle); put(4'd4, idle); put(4'd4, idle); put(4'd2, idle);
        res("basic", 4, 1, 1, 1, 1);
        tick();
        chk("basic_pulse_end", 32'(out_valid), 32'd0);
        // backpressure on frame 2,3,1,1
        out_ready = 1'b0;
        put(4'd2, idle); put(4'd3, idle); put(4'd1, idle); put(4'd1, idle);
        res("bp", 3, 1, 1, 1, 1);
        in_valid = 1'b1; in_data = 4'd15;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({out_valid, out_max, out_min, out_rise, out_fall, out_flat}), 32'({1'b1, 4'd3, 4'd1, 2'd1, 2'd1, 2'd1}));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_no_early_accept", 32'(out_max), 32'd3);
        tick();
        chk("bp_accept_after", 32'({out_max, out_min}), 32'({4'd15, 4'd15}));
        in_valid = 1'b0;
        put(4'd15, idle); put(4'd15, idle); put(4'd15, idle);
        res("bp_next", 15, 15, 0, 0, 3);
        tick();
        // back-to-back frames
        put(4'd9, idle); put(4'd9, idle); put(4'd9, idle); put(4'd9, idle);
        res("b2b_a", 9, 9, 0, 0, 3);
        put(4'd15, idle);
        chk("b2b_idle", 32'(idle), 32'd1);
        put(4'd0, idle); put(4'd15, idle); put(4'd0, idle);
        res("b2b_b", 15, 0, 1, 2, 0);
        tick();
        // input bubbles
        put(4'd3, idle); tick(); tick();
        put(4'd7, idle); tick(); tick();
        put(4'd5, idle); tick(); tick();
        put(4'd5, idle);
        res("bubble", 7, 3, 1, 1, 1);
        tick();
        // asynchronous mid-frame reset
        put(4'd8, idle); put(4'd2, idle);
        #2 rst = 1'b1;
        #1;
        chk("arst_fields", 32'({out_valid, out_max, out_min, out_rise, out_fall, out_flat}), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();
        put(4'd6, idle); put(4'd6, idle); put(4'd1, idle); put(4'd12, idle);
        res("after_rst", 12, 1, 1, 1, 1);
        tick();
        // FRAME_LEN=1 instance
        in_valid1 = 1'b1; in_data1 = 4'd7;
        tick();
        in_valid1 = 1'b0;
        chk("fl1_valid", 32'(out_valid1), 32'd1);
        chk("fl1_maxmin", 32'({out_max1, out_min1}), 32'({4'd7, 4'd7}));
        chk("fl1_counts", 32'({out_rise1, out_fall1, out_flat1}), 32'd0);
        chk("fl1_in_ready", 32'(in_ready1), 32'd0);
        out_ready1 = 1'b1;
        tick();
        chk("fl1_done", 32'({out_valid1, in_ready1}), 32'b01);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
